// File: rtl/vec_regfile_p.sv
// -----------------------------------------------------------------------------
// vec_regfile_p
//
// Parametrised vector register file for the vector datapath. It holds NREG
// registers of LANES elements, and each element is EW bits wide.
//
// Features:
//   - registered reads with same-edge write/clear bypass
//   - per-lane write masking
//   - aligned pair writes for double-width results
//   - background clear sequencer that zeroes one register per cycle
//
// Ports:
//   clk             rising-edge clock
//   rst_n           asynchronous active-low reset
//   re              read enable; rdata1/rdata2 hold while low
//   raddr1, raddr2  read addresses
//   we              single-register write request
//   dw              pair write request; wins over we
//   waddr           write address; for dw, bit 0 is ignored
//   wmask           per-lane write enable; bit i covers element i
//   wdata           write data; single writes use the low VW bits
//   clr_req         single-cycle pulse that starts the clear sequence
//   busy            the clear sequence is running
//   wr_err          one-cycle pulse after a write dropped while busy
//   rdata1, rdata2  registered read data
// -----------------------------------------------------------------------------
module vec_regfile_p #(
  parameter  int NREG  = 4,
  parameter  int LANES = 16,
  parameter  int EW    = 32,
  localparam int VW    = LANES * EW,
  localparam int AW    = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              re,
  input  logic [AW-1:0]     raddr1,
  input  logic [AW-1:0]     raddr2,
  input  logic              we,
  input  logic              dw,
  input  logic [AW-1:0]     waddr,
  input  logic [LANES-1:0]  wmask,
  input  logic [2*VW-1:0]   wdata,
  input  logic              clr_req,
  output logic              busy,
  output logic              wr_err,
  output logic [VW-1:0]     rdata1,
  output logic [VW-1:0]     rdata2
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  // Returns the old vector with the masked lanes replaced by the new lanes.
  function automatic logic [VW-1:0] merge_lanes(
    input logic [VW-1:0]    old_v,
    input logic [VW-1:0]    new_v,
    input logic [LANES-1:0] mask
  );
    logic [VW-1:0] res;
    res = old_v;
    for (int i = 0; i < LANES; i++) begin
      if (mask[i]) begin
        res[i*EW +: EW] = new_v[i*EW +: EW];
      end else begin
        res[i*EW +: EW] = old_v[i*EW +: EW];
      end
    end
    return res;
  endfunction

  state_t           state_r;
  state_t           state_nxt_s;
  logic [AW-1:0]    idx_r;
  logic [AW-1:0]    idx_nxt_s;
  logic             busy_r;
  logic             busy_nxt_s;
  logic             wr_err_r;
  logic             wr_err_nxt_s;
  logic [VW-1:0]    rdata1_r;
  logic [VW-1:0]    rdata2_r;

  logic             pair_go_s;
  logic             single_go_s;
  logic             clr_go_s;
  logic [AW-1:0]    wpair_s;

  // Post-edge value of every register; the read ports capture from this, so
  // writes and clears at the same edge are seen without a separate bypass.
  logic [VW-1:0]    nxt_all_s [NREG];

  // Write qualification: writes are dropped while busy, dw outranks we.
  always_comb begin
    pair_go_s    = dw & ~busy_r;
    single_go_s  = we & ~dw & ~busy_r;
    clr_go_s     = (state_r == ST_CLEAR);
    wpair_s      = waddr >> 1;
    wr_err_nxt_s = (we | dw) & busy_r;
  end

  for (genvar g = 0; g < NREG; g++) begin : g_reg
    localparam logic [AW-1:0] GADDR = AW'(g);

    logic [VW-1:0] reg_r;
    logic [VW-1:0] nxt_s;

    // Next value of this register. A clear can never coincide with an
    // accepted write because writes are dropped whenever busy is high.
    always_comb begin
      nxt_s = reg_r;
      if (clr_go_s && (idx_r == GADDR)) begin
        nxt_s = '0;
      end else if (pair_go_s && (wpair_s == (GADDR >> 1))) begin
        // Even member of the pair takes the upper half, odd the lower half.
        nxt_s = merge_lanes(reg_r,
                            GADDR[0] ? wdata[VW-1:0] : wdata[2*VW-1:VW],
                            wmask);
      end else if (single_go_s && (waddr == GADDR)) begin
        nxt_s = merge_lanes(reg_r, wdata[VW-1:0], wmask);
      end else begin
        nxt_s = reg_r;
      end
    end

    // Register storage.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        reg_r <= '0;
      end else begin
        reg_r <= nxt_s;
      end
    end

    assign nxt_all_s[g] = nxt_s;
  end

  // Clear sequencer next-state logic: walks idx from 0 to NREG-1.
  always_comb begin
    state_nxt_s = state_r;
    idx_nxt_s   = idx_r;
    case (state_r)
      ST_IDLE: begin
        if (clr_req) begin
          state_nxt_s = ST_CLEAR;
          idx_nxt_s   = '0;
        end else begin
          state_nxt_s = ST_IDLE;
          idx_nxt_s   = idx_r;
        end
      end
      ST_CLEAR: begin
        // clr_req is ignored here; the running sequence is not restarted.
        if (idx_r == AW'(NREG - 1)) begin
          state_nxt_s = ST_IDLE;
          idx_nxt_s   = '0;
        end else begin
          state_nxt_s = ST_CLEAR;
          idx_nxt_s   = idx_r + AW'(1);
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        idx_nxt_s   = '0;
      end
    endcase
    busy_nxt_s = (state_nxt_s == ST_CLEAR);
  end

  // Clear sequencer state, busy flag and dropped-write pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      idx_r    <= '0;
      busy_r   <= 1'b0;
      wr_err_r <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      idx_r    <= idx_nxt_s;
      busy_r   <= busy_nxt_s;
      wr_err_r <= wr_err_nxt_s;
    end
  end

  // Read ports: capture the post-edge register contents when re is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata1_r <= '0;
      rdata2_r <= '0;
    end else if (re) begin
      rdata1_r <= nxt_all_s[raddr1];
      rdata2_r <= nxt_all_s[raddr2];
    end else begin
      rdata1_r <= rdata1_r;
      rdata2_r <= rdata2_r;
    end
  end

  assign busy   = busy_r;
  assign wr_err = wr_err_r;
  assign rdata1 = rdata1_r;
  assign rdata2 = rdata2_r;

endmodule

// File: tb/tb_vec_regfile_p.sv
// -----------------------------------------------------------------------------
// tb_vec_regfile_p
//
// Directed bench for vec_regfile_p. It instantiates a default-size file
// (4 x 16 x 32) and a small file (8 x 4 x 8). Expected values are written as
// hand-computed constants.
// -----------------------------------------------------------------------------
module tb_vec_regfile_p;

  logic clk = 1'b0;
  logic rst_n;

  // Default-size instance (NREG=4, LANES=16, EW=32).
  logic          re_a, we_a, dw_a, clr_a, busy_a, wr_err_a;
  logic [1:0]    raddr1_a, raddr2_a, waddr_a;
  logic [15:0]   wmask_a;
  logic [1023:0] wdata_a;
  logic [511:0]  rd1_a, rd2_a;

  // Small instance (NREG=8, LANES=4, EW=8).
  logic          re_b, we_b, dw_b, clr_b, busy_b, wr_err_b;
  logic [2:0]    raddr1_b, raddr2_b, waddr_b;
  logic [3:0]    wmask_b;
  logic [63:0]   wdata_b;
  logic [31:0]   rd1_b, rd2_b;

  int n_assert = 0;
  int n_fail   = 0;
  int cnt;

  localparam logic [511:0] PAT01 = {64{8'h01}};
  localparam logic [511:0] ALLF  = {512{1'b1}};
  localparam logic [511:0] M1    = {{256{1'b1}}, {256{1'b0}}};
  localparam logic [511:0] VA    = {16{32'hA0A0_0A0A}};
  localparam logic [511:0] VB    = {16{32'h0B0B_B0B0}};
  localparam logic [511:0] VC    = {16{32'hC3C3_3C3C}};
  localparam logic [511:0] VD    = {16{32'hD1D1_1D1D}};
  localparam logic [511:0] VE    = {16{32'h0E0E_E0E0}};
  // Lanes 4-7 and 12-15 replaced (mask 16'hF0F0).
  localparam logic [511:0] R2 = {{4{32'hC3C3_3C3C}}, {4{32'hA0A0_0A0A}},
                                 {4{32'hC3C3_3C3C}}, {4{32'hA0A0_0A0A}}};
  localparam logic [511:0] R3 = {{4{32'hD1D1_1D1D}}, {4{32'h0B0B_B0B0}},
                                 {4{32'hD1D1_1D1D}}, {4{32'h0B0B_B0B0}}};

  vec_regfile_p u_dut_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .re      (re_a),
    .raddr1  (raddr1_a),
    .raddr2  (raddr2_a),
    .we      (we_a),
    .dw      (dw_a),
    .waddr   (waddr_a),
    .wmask   (wmask_a),
    .wdata   (wdata_a),
    .clr_req (clr_a),
    .busy    (busy_a),
    .wr_err  (wr_err_a),
    .rdata1  (rd1_a),
    .rdata2  (rd2_a)
  );

  vec_regfile_p #(.NREG(8), .LANES(4), .EW(8)) u_dut_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .re      (re_b),
    .raddr1  (raddr1_b),
    .raddr2  (raddr2_b),
    .we      (we_b),
    .dw      (dw_b),
    .waddr   (waddr_b),
    .wmask   (wmask_b),
    .wdata   (wdata_b),
    .clr_req (clr_b),
    .busy    (busy_b),
    .wr_err  (wr_err_b),
    .rdata1  (rd1_b),
    .rdata2  (rd2_b)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    re_a = 1'b0; we_a = 1'b0; dw_a = 1'b0; clr_a = 1'b0;
    raddr1_a = 2'd0; raddr2_a = 2'd0; waddr_a = 2'd0;
    wmask_a = 16'h0000; wdata_a = '0;
    re_b = 1'b0; we_b = 1'b0; dw_b = 1'b0; clr_b = 1'b0;
    raddr1_b = 3'd0; raddr2_b = 3'd0; waddr_b = 3'd0;
    wmask_b = 4'h0; wdata_b = 64'd0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rd1_a",  rd1_a,    512'd0);
    chk("rst_rd2_a",  rd2_a,    512'd0);
    chk("rst_busy_a", busy_a,   512'd0);
    chk("rst_err_a",  wr_err_a, 512'd0);
    chk("rst_rd1_b",  rd1_b,    512'd0);
    rst_n = 1'b1;

    // Single full write, then read on the next cycle
    we_a = 1'b1; waddr_a = 2'd2; wmask_a = 16'hFFFF; wdata_a = {512'd0, PAT01};
    tick();
    we_a = 1'b0;
    re_a = 1'b1; raddr1_a = 2'd2; raddr2_a = 2'd0;
    tick();
    re_a = 1'b0;
    chk("wr_rd1", rd1_a, PAT01);
    chk("wr_rd2", rd2_a, 512'd0);
    chk("wr_err_none", wr_err_a, 512'd0);

    // Outputs hold while re is low
    raddr1_a = 2'd0;
    tick();
    chk("read_hold", rd1_a, PAT01);

    // Masked write
    we_a = 1'b1; waddr_a = 2'd1; wmask_a = 16'hFFFF; wdata_a = {512'd0, ALLF};
    tick();
    wmask_a = 16'h00FF; wdata_a = '0;
    tick();
    we_a = 1'b0;
    re_a = 1'b1; raddr1_a = 2'd1; raddr2_a = 2'd2;
    tick();
    re_a = 1'b0;
    chk("mask_rd1", rd1_a, M1);
    chk("mask_rd2", rd2_a, PAT01);

    // Pair write with same-edge reads of both halves, we concurrently set
    dw_a = 1'b1; we_a = 1'b1; waddr_a = 2'd3; wmask_a = 16'hFFFF; wdata_a = {VA, VB};
    re_a = 1'b1; raddr1_a = 2'd2; raddr2_a = 2'd3;
    tick();
    chk("pair_byp_rd1", rd1_a, VA);
    chk("pair_byp_rd2", rd2_a, VB);
    chk("pair_err", wr_err_a, 512'd0);

    // Masked pair at even base with we set: single write must not happen
    waddr_a = 2'd2; wmask_a = 16'hF0F0; wdata_a = {VC, VD};
    tick();
    dw_a = 1'b0; we_a = 1'b0;
    chk("mpair_byp_rd1", rd1_a, R2);
    chk("mpair_byp_rd2", rd2_a, R3);
    chk("mpair_err", wr_err_a, 512'd0);

    // Other registers untouched by pair writes
    raddr1_a = 2'd0; raddr2_a = 2'd1;
    tick();
    re_a = 1'b0;
    chk("untouched_r0", rd1_a, 512'd0);
    chk("untouched_r1", rd2_a, M1);

    // Preload reg0 so all four registers are nonzero
    we_a = 1'b1; waddr_a = 2'd0; wmask_a = 16'hFFFF; wdata_a = {512'd0, VE};
    tick();
    we_a = 1'b0;

    // Clear sequence
    clr_a = 1'b1;
    tick();                                   // E0
    clr_a = 1'b0;
    chk("clr_busy_e0", busy_a, 512'd1);
    tick();                                   // E1: reg0 cleared
    chk("clr_busy_e1", busy_a, 512'd1);
    we_a = 1'b1; waddr_a = 2'd3; wmask_a = 16'hFFFF; wdata_a = {512'd0, ALLF};
    re_a = 1'b1; raddr1_a = 2'd1; raddr2_a = 2'd3;
    tick();                                   // E2: reg1 cleared, write dropped
    we_a = 1'b0; re_a = 1'b0;
    chk("clr_err_pulse", wr_err_a, 512'd1);
    chk("clr_busy_e2",   busy_a,   512'd1);
    chk("clr_byp_zero",  rd1_a,    512'd0);
    chk("clr_drop_r3",   rd2_a,    R3);
    clr_a = 1'b1;                             // ignored while busy
    tick();                                   // E3
    clr_a = 1'b0;
    chk("clr_err_end",  wr_err_a, 512'd0);
    chk("clr_busy_e3",  busy_a,   512'd1);
    tick();                                   // E4: last register cleared
    chk("clr_busy_e4",  busy_a,   512'd0);
    tick();
    chk("clr_no_restart", busy_a, 512'd0);
    re_a = 1'b1; raddr1_a = 2'd0; raddr2_a = 2'd1;
    tick();
    chk("clr_r0", rd1_a, 512'd0);
    chk("clr_r1", rd2_a, 512'd0);
    raddr1_a = 2'd2; raddr2_a = 2'd3;
    tick();
    re_a = 1'b0;
    chk("clr_r2", rd1_a, 512'd0);
    chk("clr_r3", rd2_a, 512'd0);

    // Reset in the middle of a clear
    we_a = 1'b1; waddr_a = 2'd2; wmask_a = 16'hFFFF; wdata_a = {512'd0, ALLF};
    tick();
    we_a = 1'b0;
    clr_a = 1'b1; re_a = 1'b1; raddr1_a = 2'd2; raddr2_a = 2'd2;
    tick();                                   // E0
    clr_a = 1'b0; re_a = 1'b0;
    chk("mid_pre_rd1", rd1_a, ALLF);
    tick();                                   // E1
    chk("mid_busy_pre", busy_a, 512'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_busy_rst", busy_a, 512'd0);
    chk("mid_rd1_rst",  rd1_a,  512'd0);
    rst_n = 1'b1;
    re_a = 1'b1; raddr1_a = 2'd2; raddr2_a = 2'd3;
    tick();
    re_a = 1'b0;
    chk("mid_r2", rd1_a, 512'd0);
    chk("mid_r3", rd2_a, 512'd0);
    we_a = 1'b1; waddr_a = 2'd1; wmask_a = 16'hFFFF; wdata_a = {512'd0, PAT01};
    tick();
    we_a = 1'b0;
    chk("mid_wr_err", wr_err_a, 512'd0);
    chk("mid_busy",   busy_a,   512'd0);
    re_a = 1'b1; raddr1_a = 2'd1;
    tick();
    re_a = 1'b0;
    chk("mid_wr_rd", rd1_a, PAT01);

    // Small instance: pair writes at base 6, reg5 must be preserved
    we_b = 1'b1; waddr_b = 3'd5; wmask_b = 4'hF; wdata_b = {32'd0, 32'h5555_5555};
    tick();
    we_b = 1'b0;
    dw_b = 1'b1; waddr_b = 3'd6; wdata_b = {32'hDEAD_BEEF, 32'h0123_4567};
    tick();
    waddr_b = 3'd7; wmask_b = 4'b0101; wdata_b = {32'h1122_3344, 32'hAABB_CCDD};
    tick();
    dw_b = 1'b0;
    re_b = 1'b1; raddr1_b = 3'd6; raddr2_b = 3'd7;
    tick();
    chk("b_r6", rd1_b, 512'h DE22_BE44);
    chk("b_r7", rd2_b, 512'h 01BB_45DD);
    raddr1_b = 3'd5; raddr2_b = 3'd4;
    tick();
    re_b = 1'b0;
    chk("b_r5", rd1_b, 512'h 5555_5555);
    chk("b_r4", rd2_b, 512'd0);

    // Small instance: clear lasts NREG cycles
    clr_b = 1'b1;
    tick();
    clr_b = 1'b0;
    cnt = 0;
    for (int i = 0; i < 20 && busy_b; i++) begin
      cnt++;
      tick();
    end
    chk("b_clr_len",  32'(cnt), 512'd8);
    chk("b_clr_done", busy_b,   512'd0);
    re_b = 1'b1; raddr1_b = 3'd6; raddr2_b = 3'd5;
    tick();
    re_b = 1'b0;
    chk("b_clr_r6", rd1_b, 512'd0);
    chk("b_clr_r5", rd2_b, 512'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
